bsg_cover_toggle_mc: RTL and testbench

BSG_COVER_TOGGLE_MC -- requirements
Module: bsg_cover_toggle_mc

---
 rtl/bsg_cover_toggle_mc.sv | 213 +++++++++++++++++++++
 tb/tb_bsg_cover_toggle_mc.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_cover_toggle_mc.sv
// Multi-channel toggle-coverage bitmap: per-channel FIFOs feed a read/modify/write pipeline.
// Define BSG_COVER_HIT_COUNT_EN to build the first-hit counter on hit_count_o.
module bsg_cover_toggle_mc #(
    parameter int unsigned num_chan_p       = 2,
    parameter int unsigned width_p          = 10,
    parameter int unsigned lg_fifo_size_p   = 2,
    parameter int unsigned mem_width_p      = 64,
    localparam int unsigned lg_mem_lp        = $clog2(mem_width_p),
    localparam int unsigned rows_per_chan_lp = 2 ** (width_p - lg_mem_lp),
    localparam int unsigned rows_lp          = num_chan_p * rows_per_chan_lp,
    localparam int unsigned addr_w_lp        = (rows_lp > 1) ? $clog2(rows_lp) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [num_chan_p-1:0]         v_i,
    input  logic [num_chan_p*width_p-1:0] data_i,
    output logic [num_chan_p-1:0]         ready_o,
    input  logic                          rd_v_i,
    input  logic [addr_w_lp-1:0]          rd_addr_i,
    input  logic                          rd_clear_i,
    output logic                          rd_ready_o,
    output logic                          rd_v_o,
    output logic [mem_width_p-1:0]        rd_data_o,
    output logic                          init_done_o,
    output logic [31:0]                   hit_count_o
);

    localparam int unsigned bit_w_lp  = (lg_mem_lp > 0) ? lg_mem_lp : 1;
    localparam int unsigned depth_lp  = 2 ** lg_fifo_size_p;
    localparam int unsigned ptr_w_lp  = (lg_fifo_size_p > 0) ? lg_fifo_size_p : 1;
    localparam int unsigned cnt_w_lp  = lg_fifo_size_p + 1;
    localparam int unsigned chan_w_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e                 r_state, w_state_nxt;
    logic [addr_w_lp-1:0]   r_clr_row, w_clr_row_nxt;

    logic [mem_width_p-1:0] r_mem [rows_lp];
    logic [width_p-1:0]     r_fifo [num_chan_p][depth_lp];
    logic [ptr_w_lp-1:0]    r_wptr [num_chan_p];
    logic [ptr_w_lp-1:0]    r_rptr [num_chan_p];
    logic [cnt_w_lp-1:0]    r_cnt [num_chan_p];
    logic [cnt_w_lp-1:0]    w_cnt_nxt [num_chan_p];
    logic [num_chan_p-1:0]  r_ready, w_push, w_pop, w_nonempty;

    logic                   r_rd_ready, r_rd_v, r_init_done;
    logic [chan_w_lp-1:0]   r_rr_ptr, w_grant;
    logic                   w_grant_v, w_host, w_run;
    logic                   w_iss_v, w_iss_rd, w_iss_clr;
    logic [addr_w_lp-1:0]   w_iss_row;
    logic [bit_w_lp-1:0]    w_iss_bit;
    logic [width_p-1:0]     w_head;

    logic                   r_s1_v, r_s1_rd, r_s1_clr;
    logic [addr_w_lp-1:0]   r_s1_row;
    logic [bit_w_lp-1:0]    r_s1_bit;
    logic [mem_width_p-1:0] r_s1_data, w_s1_wdata, w_rd_fwd;
    logic                   w_s1_wen;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(depth_lp - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // Init sweep: zero one row per cycle, then run forever.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= ST_CLEAR;
            r_clr_row <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_row <= w_clr_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_row_nxt = r_clr_row;
        if (r_state == ST_CLEAR) begin
            if (r_clr_row == addr_w_lp'(rows_lp - 1)) begin
                w_state_nxt   = ST_RUN;
                w_clr_row_nxt = '0;
            end else begin
                w_clr_row_nxt = r_clr_row + addr_w_lp'(1);
            end
        end
    end

    assign w_run = (r_state == ST_RUN);

    // Round-robin: first non-empty channel at or after the pointer, then wrap.
    always_comb begin
        w_grant_v = 1'b0;
        w_grant   = '0;
        for (int c = 0; c < num_chan_p; c++) begin
            if (!w_grant_v && w_nonempty[c] && (c >= int'(r_rr_ptr))) begin
                w_grant_v = 1'b1;
                w_grant   = chan_w_lp'(c);
            end
        end
        for (int c = 0; c < num_chan_p; c++) begin
            if (!w_grant_v && w_nonempty[c] && (c < int'(r_rr_ptr))) begin
                w_grant_v = 1'b1;
                w_grant   = chan_w_lp'(c);
            end
        end
    end

    assign w_host    = rd_v_i & r_rd_ready;
    assign w_head    = r_fifo[w_grant][r_rptr[w_grant]];
    assign w_iss_v   = w_host | (w_grant_v & w_run);
    assign w_iss_rd  = w_host;
    assign w_iss_clr = w_host & rd_clear_i;
    assign w_iss_row = w_host ? rd_addr_i
                     : addr_w_lp'(int'(w_grant) * rows_per_chan_lp) + addr_w_lp'(w_head >> lg_mem_lp);
    assign w_iss_bit = w_host ? '0 : bit_w_lp'(w_head);

    always_comb begin
        for (int c = 0; c < num_chan_p; c++) begin
            w_nonempty[c] = (r_cnt[c] != '0);
            w_push[c]     = v_i[c] & r_ready[c];
            w_pop[c]      = !w_host && w_grant_v && w_run && (w_grant == chan_w_lp'(c));
            w_cnt_nxt[c]  = r_cnt[c] + cnt_w_lp'(w_push[c]) - cnt_w_lp'(w_pop[c]);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_ready <= '0;
            for (int c = 0; c < num_chan_p; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
                r_cnt[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < num_chan_p; c++) begin
                if (w_push[c]) r_wptr[c] <= ptr_inc(r_wptr[c]);
                if (w_pop[c])  r_rptr[c] <= ptr_inc(r_rptr[c]);
                r_cnt[c]   <= w_cnt_nxt[c];
                r_ready[c] <= w_run && (w_cnt_nxt[c] != cnt_w_lp'(depth_lp));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < num_chan_p; c++) begin
            if (w_push[c]) r_fifo[c][r_wptr[c]] <= data_i[c*width_p +: width_p];
        end
    end

    // The row being written this edge is forwarded into the op being read this edge.
    assign w_s1_wen   = r_s1_v & (~r_s1_rd | r_s1_clr);
    assign w_s1_wdata = r_s1_rd ? '0 : (r_s1_data | (mem_width_p'(1) << r_s1_bit));
    assign w_rd_fwd   = (w_s1_wen && (r_s1_row == w_iss_row)) ? w_s1_wdata : r_mem[w_iss_row];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_s1_v      <= 1'b0;
            r_s1_rd     <= 1'b0;
            r_s1_clr    <= 1'b0;
            r_s1_row    <= '0;
            r_s1_bit    <= '0;
            r_rr_ptr    <= '0;
            r_rd_v      <= 1'b0;
            r_rd_ready  <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_s1_v      <= w_iss_v;
            r_s1_rd     <= w_iss_rd;
            r_s1_clr    <= w_iss_clr;
            r_s1_row    <= w_iss_row;
            r_s1_bit    <= w_iss_bit;
            r_rd_v      <= w_host;
            r_rd_ready  <= w_run;
            r_init_done <= w_run;
            if (w_grant_v && !w_host && w_run) begin
                r_rr_ptr <= (w_grant == chan_w_lp'(num_chan_p - 1)) ? '0 : w_grant + chan_w_lp'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_row] <= '0;
        end else if (w_s1_wen) begin
            r_mem[r_s1_row] <= w_s1_wdata;
        end
        if (w_iss_v) r_s1_data <= w_rd_fwd;
    end

`ifdef BSG_COVER_HIT_COUNT_EN
    logic [31:0] r_hit;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_hit <= '0;
        end else if (w_s1_wen && !r_s1_rd && !r_s1_data[r_s1_bit] && (r_hit != 32'hFFFF_FFFF)) begin
            r_hit <= r_hit + 32'd1;
        end
    end

    assign hit_count_o = r_hit;
`else
    assign hit_count_o = '0;
`endif

    assign ready_o     = r_ready;
    assign rd_ready_o  = r_rd_ready;
    assign rd_v_o      = r_rd_v;
    assign rd_data_o   = r_s1_data;
    assign init_done_o = r_init_done;

endmodule

// File: tb/tb_bsg_cover_toggle_mc.sv
// Randomized scoreboard bench for bsg_cover_toggle_mc against a flat-bitmap reference model.
module tb_bsg_cover_toggle_mc;

    localparam int unsigned NCH  = 2;
    localparam int unsigned W    = 10;
    localparam int unsigned MW   = 64;
    localparam int unsigned ROWS = NCH * (1 << W) / MW;
    localparam int unsigned AW   = $clog2(ROWS);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NCH-1:0]      v_i = '0;
    logic [NCH*W-1:0]    data_i = '0;
    logic [NCH-1:0]      ready_o;
    logic                rd_v_i = 1'b0;
    logic [AW-1:0]       rd_addr_i = '0;
    logic                rd_clear_i = 1'b0;
    logic                rd_ready_o;
    logic                rd_v_o;
    logic [MW-1:0]       rd_data_o;
    logic                init_done_o;
    logic [31:0]         hit_count_o;

    bsg_cover_toggle_mc #(
        .num_chan_p(NCH), .width_p(W), .lg_fifo_size_p(2), .mem_width_p(MW)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
        .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i), .rd_clear_i(rd_clear_i),
        .rd_ready_o(rd_ready_o), .rd_v_o(rd_v_o), .rd_data_o(rd_data_o),
        .init_done_o(init_done_o), .hit_count_o(hit_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        int unsigned cyc;
        int unsigned row;
    } exp_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    bit          model_bits [NCH * (1 << W)];
    int unsigned model_hits = 0;
    exp_t        sb_q[$];
    exp_t        mon_e;
    int unsigned pq[NCH][$];
    bit          full_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Row r of the bitmap is the 64 consecutive coverage points starting at r*64 in channel-major order.
    function automatic logic [63:0] model_row(input int unsigned row);
        logic [63:0] v;
        for (int b = 0; b < 64; b++) v[b] = model_bits[row * 64 + b];
        return v;
    endfunction

    function automatic logic [63:0] hit_exp();
`ifdef BSG_COVER_HIT_COUNT_EN
        return 64'(model_hits);
`else
        return 64'd0;
`endif
    endfunction

    task automatic record(input int unsigned c, input int unsigned p);
        int unsigned idx = c * (1 << W) + p;
        if (!model_bits[idx]) model_hits++;
        model_bits[idx] = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH * (1 << W); i++) model_bits[i] = 1'b0;
        model_hits = 0;
        sb_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rd_v_o pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rd_v_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_unexpected: got rd_v_o=1 data 0x%0h, expected no read", rd_data_o);
            end else begin
                mon_e = sb_q.pop_front();
                check($sformatf("rd_row%0d_data", mon_e.row), rd_data_o, mon_e.data);
                check($sformatf("rd_row%0d_latency", mon_e.row), 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic host_reads(input int unsigned rows[$], input bit clrs[$]);
        int unsigned k = 0;
        int unsigned guard = 0;
        while (k < rows.size()) begin
            rd_v_i     = 1'b1;
            rd_addr_i  = AW'(rows[k]);
            rd_clear_i = clrs[k];
            @(negedge clk);
            if (rd_ready_o) begin
                sb_q.push_back('{model_row(rows[k]), cyc + 1, rows[k]});
                if (clrs[k]) for (int b = 0; b < 64; b++) model_bits[rows[k] * 64 + b] = 1'b0;
                k++;
            end
            guard++;
            tick();
            if (guard > 1000) begin
                timeout("rd_accept");
                break;
            end
        end
        rd_v_i     = 1'b0;
        rd_clear_i = 1'b0;
    endtask

    task automatic send_pending();
        int unsigned guard = 0;
        bit acc [NCH];
        while (pq[0].size() + pq[1].size() > 0) begin
            for (int c = 0; c < NCH; c++) begin
                v_i[c] = (pq[c].size() > 0);
                if (pq[c].size() > 0) data_i[c*W +: W] = W'(pq[c][0]);
            end
            @(negedge clk);
            for (int c = 0; c < NCH; c++) acc[c] = v_i[c] && ready_o[c];
            if (v_i[1] && !ready_o[1]) full_seen = 1'b1;
            tick();
            for (int c = 0; c < NCH; c++) if (acc[c]) record(c, pq[c].pop_front());
            guard++;
            if (guard > 2000) begin
                timeout("point_accept");
                for (int c = 0; c < NCH; c++) pq[c].delete();
            end
        end
        v_i = '0;
    endtask

    task automatic read_all(input bit rand_clear);
        int unsigned rows[$];
        bit clrs[$];
        for (int r = 0; r < ROWS; r++) begin
            rows.push_back(r);
            clrs.push_back(rand_clear && ($urandom_range(0, 3) == 0));
        end
        host_reads(rows, clrs);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) tick();
    endtask

    task automatic check_reset_outputs();
        check("reset_outputs", 64'({ready_o, rd_ready_o, rd_v_o, init_done_o, hit_count_o}), 64'd0);
    endtask

    // Release reset and time the sweep: init_done_o on the 33rd edge, ready low throughout.
    task automatic release_and_init();
        int unsigned n = 0;
        bit pre_ok = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (init_done_o) break;
            if (ready_o != '0 || rd_ready_o) pre_ok = 1'b0;
        end
        if (!init_done_o) timeout("init_done");
        check("init_latency", 64'(n), 64'd33);
        check("ready_low_in_clear", 64'(pre_ok), 64'd1);
        tick();
    endtask

    initial begin
        int unsigned rows[$];
        bit clrs[$];

        model_reset();
        #2;
        check_reset_outputs();
        release_and_init();

        pq[0].push_back(10'h041);
        send_pending();
        idle(8);
        rows = '{1}; clrs = '{0};
        host_reads(rows, clrs);
        idle(3);
        check("hit_after_0x041", 64'(hit_count_o), hit_exp());

        pq[0].push_back(10'h005);
        pq[1].push_back(10'h005);
        send_pending();
        idle(8);
        rows = '{0, 16}; clrs = '{0, 0};
        host_reads(rows, clrs);
        idle(3);
        check("hit_two_chan_same_pt", 64'(hit_count_o), hit_exp());
        pq[0].push_back(10'h005);
        send_pending();
        idle(8);
        check("hit_repeat_pt", 64'(hit_count_o), hit_exp());

        pq[0].push_back(10'h0C0);
        send_pending();
        idle(8);
        rows = '{3, 3}; clrs = '{1, 0};
        host_reads(rows, clrs);
        pq[0].push_back(10'h0C2);
        send_pending();
        idle(8);
        rows = '{3}; clrs = '{0};
        host_reads(rows, clrs);
        idle(3);
        check("hit_after_clear", 64'(hit_count_o), hit_exp());

        // Back-pressure: host reads every cycle starve the arbiter while chan1 piles up.
        for (int i = 0; i < 8; i++) pq[1].push_back($urandom_range(0, 1023));
        rows.delete();
        clrs.delete();
        for (int i = 0; i < 24; i++) begin
            rows.push_back(i % 16);
            clrs.push_back(1'b0);
        end
        fork
            send_pending();
            host_reads(rows, clrs);
        join
        check("ch1_backpressure_seen", 64'(full_seen), 64'd1);
        idle(12);
        read_all(1'b0);
        idle(3);
        check("hit_after_backpressure", 64'(hit_count_o), hit_exp());

        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NCH; c++) begin
                int unsigned cnt = $urandom_range(0, 12);
                for (int i = 0; i < cnt; i++) pq[c].push_back($urandom_range(0, (r % 2) ? 1023 : 255));
            end
            send_pending();
            idle(12);
            check($sformatf("hit_round%0d", r), 64'(hit_count_o), hit_exp());
            read_all(1'b1);
            idle(3);
        end
        check("sb_drained_pre_reset", 64'(sb_q.size()), 64'd0);

        // Reset mid-sweep, then mid-traffic; both must restart the full sweep.
        rst_n = 1'b0;
        model_reset();
        #2;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        rst_n = 1'b0;
        #2;
        check_reset_outputs();
        release_and_init();

        for (int i = 0; i < 6; i++) begin
            v_i = '1;
            data_i = (NCH*W)'($urandom);
            tick();
        end
        rst_n = 1'b0;
        v_i = '0;
        model_reset();
        #2;
        check_reset_outputs();
        idle(2);
        release_and_init();
        read_all(1'b0);
        idle(3);
        check("hit_after_reset", 64'(hit_count_o), hit_exp());
        check("sb_drained_final", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
